// File: rtl/mult_arbiter.sv
// Round-robin sharing of one multiplier among NREQ level requesters; grant -> START -> END/timeout -> one-cycle ACK.
// Latency: grant edge + 1 (START) + multiplier latency + 1 (ACK); requests must be held until ACK, no other backpressure.
module mult_arbiter #(
    parameter  int tamano  = 8,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 64,
    localparam int IW      = $clog2(NREQ),
    localparam int WW      = $clog2(TIMEOUT)
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [NREQ-1:0]          REQ,
    input  logic [NREQ*tamano-1:0]   REQ_A,
    input  logic [NREQ*tamano-1:0]   REQ_B,
    output logic [NREQ-1:0]          ACK,
    output logic                     ERR,
    output logic [2*tamano-1:0]      RESULT,
    output logic                     BUSY,
    output logic [IW-1:0]            GRANT_ID,
    output logic                     MULT_START,
    output logic [tamano-1:0]        MULT_A,
    output logic [tamano-1:0]        MULT_B,
    input  logic [2*tamano-1:0]      MULT_S,
    input  logic                     MULT_END
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_gid;
    logic [WW-1:0]       r_wd;
    logic [NREQ-1:0]     r_ack;
    logic                r_err;
    logic [2*tamano-1:0] r_result;
    logic                r_busy;
    logic                r_start;
    logic [tamano-1:0]   r_a;
    logic [tamano-1:0]   r_b;

    logic                w_any;
    logic [IW-1:0]       w_win;

    // (base + off) mod NREQ; both operands are already below NREQ
    function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return s[IW-1:0];
    endfunction

    // Scan from the farthest offset down so the nearest set request at/after r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (REQ[f_wrap(r_ptr, k)]) begin
                w_any = 1'b1;
                w_win = f_wrap(r_ptr, k);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_gid    <= '0;
            r_wd     <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any && !MULT_END) begin
                        r_gid   <= w_win;
                        r_a     <= REQ_A[w_win*tamano +: tamano];
                        r_b     <= REQ_B[w_win*tamano +: tamano];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start <= 1'b0;
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A real END beats a coincident watchdog expiry.
                    if (MULT_END) begin
                        r_result <= MULT_S;
                        r_ack    <= {{(NREQ-1){1'b0}}, 1'b1} << r_gid;
                        r_err    <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (r_wd == WW'(TIMEOUT - 1)) begin
                        r_result <= '0;
                        r_ack    <= {{(NREQ-1){1'b0}}, 1'b1} << r_gid;
                        r_err    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_ptr   <= f_wrap(r_gid, 1);
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ACK        = r_ack;
    assign ERR        = r_err;
    assign RESULT     = r_result;
    assign BUSY       = r_busy;
    assign GRANT_ID   = r_gid;
    assign MULT_START = r_start;
    assign MULT_A     = r_a;
    assign MULT_B     = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a simple behavioural multiplier driving MULT_S/MULT_END.
module tb_mult_arbiter;

    localparam int TW = 8;
    localparam int NR = 4;
    localparam int TO = 16;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic [NR-1:0] REQ;
    logic [NR*TW-1:0] REQ_A;
    logic [NR*TW-1:0] REQ_B;
    logic [NR-1:0] ACK;
    logic          ERR;
    logic [2*TW-1:0] RESULT;
    logic          BUSY;
    logic [1:0]    GRANT_ID;
    logic          MULT_START;
    logic [TW-1:0] MULT_A;
    logic [TW-1:0] MULT_B;
    logic [2*TW-1:0] MULT_S;
    logic          MULT_END;

    int checks   = 0;
    int failures = 0;
    bit mult_en  = 1'b1;
    int mult_lat = 2;

    mult_arbiter #(.tamano(TW), .NREQ(NR), .TIMEOUT(TO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .ACK(ACK), .ERR(ERR), .RESULT(RESULT), .BUSY(BUSY), .GRANT_ID(GRANT_ID),
        .MULT_START(MULT_START), .MULT_A(MULT_A), .MULT_B(MULT_B),
        .MULT_S(MULT_S), .MULT_END(MULT_END)
    );

    always #5 CLOCK = ~CLOCK;

    // END is raised mult_lat negedges after START is seen and is sampled on the following rising edge.
    initial begin : mult_model
        logic [2*TW-1:0] prod;
        MULT_S   = '0;
        MULT_END = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (mult_en && MULT_START === 1'b1) begin
                prod = MULT_A * MULT_B;
                repeat (mult_lat) @(negedge CLOCK);
                MULT_S   = prod;
                MULT_END = 1'b1;
                @(negedge CLOCK);
                MULT_END = 1'b0;
            end
        end
    end

    initial begin : global_guard
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        REQ_A[i*TW +: TW] = a[TW-1:0];
        REQ_B[i*TW +: TW] = b[TW-1:0];
    endtask

    task automatic wait_start();
        for (int i = 0; i < 200; i++) begin
            if (MULT_START === 1'b1) break;
            tick(1);
        end
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 200; i++) begin
            if (ACK !== '0) break;
            tick(1);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick(2);
        RESET = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        bit seen;
        tick(3);
        checks++;
        if ({ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B} !== '0) begin
            failures++;
            $display("FAIL reset_initial: got %h required 0", {ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B});
        end
        RESET = 1'b1;
        tick(1);
        mult_en = 1'b0;
        set_ops(0, 7, 9);
        REQ = 4'b0001;
        wait_start();
        tick(3);
        checks++;
        if (BUSY !== 1'b1 || MULT_A !== 8'd7) begin
            failures++;
            $display("FAIL reset_prewait: got busy=%b a=%0d required busy=1 a=7", BUSY, MULT_A);
        end
        RESET = 1'b0;
        REQ   = '0;
        #1;
        checks++;
        if ({ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B} !== '0) begin
            failures++;
            $display("FAIL reset_async: got %h required 0", {ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B});
        end
        tick(5);
        checks++;
        if ({ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B} !== '0) begin
            failures++;
            $display("FAIL reset_held: got %h required 0", {ACK, ERR, RESULT, BUSY, GRANT_ID, MULT_START, MULT_A, MULT_B});
        end
        RESET = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            tick(1);
            if (MULT_START !== 1'b0 || BUSY !== 1'b0 || ACK !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet: activity seen=%b required 0", seen);
        end
        mult_en = 1'b1;
    endtask

    task automatic test_single();
        set_ops(1, 3, 5);
        REQ = 4'b0010;
        wait_start();
        checks++;
        if (MULT_START !== 1'b1 || MULT_A !== 8'd3 || MULT_B !== 8'd5 || GRANT_ID !== 2'd1 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL single_issue: got start=%b a=%0d b=%0d gid=%0d busy=%b required 1 3 5 1 1",
                     MULT_START, MULT_A, MULT_B, GRANT_ID, BUSY);
        end
        tick(1);
        checks++;
        if (MULT_START !== 1'b0) begin
            failures++;
            $display("FAIL single_start_pulse: got %b required 0", MULT_START);
        end
        wait_ack();
        checks++;
        if (ACK !== 4'b0010 || RESULT !== 16'd15 || ERR !== 1'b0 || GRANT_ID !== 2'd1) begin
            failures++;
            $display("FAIL single_ack: got ack=%b res=%0d err=%b gid=%0d required 0010 15 0 1", ACK, RESULT, ERR, GRANT_ID);
        end
        REQ = '0;
        tick(1);
        checks++;
        if (ACK !== 4'b0000 || RESULT !== 16'd15 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_pulse: got ack=%b res=%0d err=%b required 0000 15 0", ACK, RESULT, ERR);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_ack;
        int            exp_res;
        do_reset();
        for (int i = 0; i < NR; i++) set_ops(i, i*10 + 1, 2);
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack();
            exp_ack = 4'b0001 << (k % NR);
            exp_res = ((k % NR) * 10 + 1) * 2;
            checks++;
            if (ACK !== exp_ack || RESULT !== 16'(exp_res) || ERR !== 1'b0) begin
                failures++;
                $display("FAIL rr_ack%0d: got ack=%b res=%0d err=%b required %b %0d 0", k, ACK, RESULT, ERR, exp_ack, exp_res);
            end
            if (k == 4) REQ = '0;
            tick(1);
            checks++;
            if (ACK !== '0) begin
                failures++;
                $display("FAIL rr_gap%0d: got ack=%b required 0000", k, ACK);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_ops(2, 4, 4);
        REQ = 4'b0100;
        wait_ack();
        REQ = '0;
        tick(1);
        checks++;
        if (GRANT_ID !== 2'd2) begin
            failures++;
            $display("FAIL wrap_setup_gid: got %0d required 2", GRANT_ID);
        end
        set_ops(0, 5, 6);
        set_ops(2, 7, 8);
        set_ops(3, 9, 9);
        REQ = 4'b0101;
        wait_ack();
        checks++;
        if (ACK !== 4'b0001 || RESULT !== 16'd30) begin
            failures++;
            $display("FAIL wrap_first: got ack=%b res=%0d required 0001 30", ACK, RESULT);
        end
        REQ = 4'b0100;
        tick(1);
        wait_ack();
        checks++;
        if (ACK !== 4'b0100 || RESULT !== 16'd56) begin
            failures++;
            $display("FAIL wrap_second: got ack=%b res=%0d required 0100 56", ACK, RESULT);
        end
        REQ = '0;
        tick(1);
    endtask

    task automatic test_timeout();
        int cnt;
        mult_en = 1'b0;
        set_ops(0, 9, 9);
        REQ = 4'b0001;
        wait_start();
        checks++;
        if (MULT_START !== 1'b1) begin
            failures++;
            $display("FAIL to_start: got %b required 1", MULT_START);
        end
        tick(1);
        for (cnt = 0; cnt < 200 && ACK === '0; cnt++) tick(1);
        checks++;
        if (cnt != TO || ACK !== 4'b0001 || ERR !== 1'b1 || RESULT !== 16'd0) begin
            failures++;
            $display("FAIL to_abort: got cycles=%0d ack=%b err=%b res=%0d required %0d 0001 1 0", cnt, ACK, ERR, RESULT, TO);
        end
        REQ = '0;
        tick(1);
        checks++;
        if (ACK !== '0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL to_clear: got ack=%b err=%b required 0000 0", ACK, ERR);
        end
        mult_en = 1'b1;
        set_ops(1, 12, 12);
        REQ = 4'b0010;
        wait_ack();
        checks++;
        if (ACK !== 4'b0010 || ERR !== 1'b0 || RESULT !== 16'd144) begin
            failures++;
            $display("FAIL to_recover: got ack=%b err=%b res=%0d required 0010 0 144", ACK, ERR, RESULT);
        end
        REQ = '0;
        tick(1);
    endtask

    task automatic test_end_vs_timeout();
        mult_lat = TO;
        set_ops(0, 3, 3);
        REQ = 4'b0001;
        wait_ack();
        checks++;
        if (ACK !== 4'b0001 || ERR !== 1'b0 || RESULT !== 16'd9) begin
            failures++;
            $display("FAIL tie_end_wins: got ack=%b err=%b res=%0d required 0001 0 9", ACK, ERR, RESULT);
        end
        REQ = '0;
        tick(1);
        mult_lat = TO + 1;
        set_ops(0, 4, 4);
        REQ = 4'b0001;
        wait_ack();
        checks++;
        if (ACK !== 4'b0001 || ERR !== 1'b1 || RESULT !== 16'd0) begin
            failures++;
            $display("FAIL late_end_timeout: got ack=%b err=%b res=%0d required 0001 1 0", ACK, ERR, RESULT);
        end
        REQ = '0;
        tick(2);
        checks++;
        if (ACK !== '0 || BUSY !== 1'b0 || RESULT !== 16'd0) begin
            failures++;
            $display("FAIL late_end_ignored: got ack=%b busy=%b res=%0d required 0000 0 0", ACK, BUSY, RESULT);
        end
        mult_lat = 2;
        tick(1);
    endtask

    task automatic test_boundary();
        set_ops(2, 255, 255);
        REQ = 4'b0100;
        wait_ack();
        checks++;
        if (ACK !== 4'b0100 || RESULT !== 16'd65025 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL bnd_max: got ack=%b res=%0d err=%b required 0100 65025 0", ACK, RESULT, ERR);
        end
        REQ = '0;
        tick(1);
        set_ops(2, 200, 150);
        REQ = 4'b0100;
        wait_start();
        REQ = '0;
        set_ops(2, 1, 1);
        tick(2);
        checks++;
        if (MULT_A !== 8'd200 || MULT_B !== 8'd150) begin
            failures++;
            $display("FAIL bnd_operand_hold: got a=%0d b=%0d required 200 150", MULT_A, MULT_B);
        end
        wait_ack();
        checks++;
        if (ACK !== 4'b0100 || RESULT !== 16'd30000) begin
            failures++;
            $display("FAIL bnd_dropped_req: got ack=%b res=%0d required 0100 30000", ACK, RESULT);
        end
        tick(1);
        set_ops(2, 0, 0);
        REQ = 4'b0100;
        wait_ack();
        checks++;
        if (ACK !== 4'b0100 || RESULT !== 16'd0 || ERR !== 1'b0) begin
            failures++;
            $display("FAIL bnd_zero: got ack=%b res=%0d err=%b required 0100 0 0", ACK, RESULT, ERR);
        end
        REQ = '0;
        tick(1);
    endtask

    initial begin
        RESET = 1'b0;
        REQ   = '0;
        REQ_A = '0;
        REQ_B = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeout();
        test_end_vs_timeout();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multipli instance (START/A/B/S/END_MULT handshake) among NREQ requesters. It latches the winning requester's operands, pulses the multiplier START, and waits for END_MULT. It then returns the 2*tamano product with a one-cycle ACK to the winner. A watchdog aborts operations whose END_MULT never arrives.

Parameters:
tamano, 8, operand width of the shared multiplier
NREQ, 4, number of requesters (>=2)
TIMEOUT, 64, max cycles in WAIT before abort (>=4)

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous reset, active-low
REQ  in  NREQ  per-requester request, level, held until ACK
REQ_A  in  NREQ*tamano  packed operand A, slice i = requester i
REQ_B  in  NREQ*tamano  packed operand B, slice i = requester i
ACK  out  NREQ  one-hot one-cycle completion pulse
ERR  out  1  high with ACK when the operation timed out
RESULT  out  2*tamano  product, valid while ACK is nonzero, held otherwise
BUSY  out  1  high in every state except IDLE
GRANT_ID  out  $clog2(NREQ)  index of current/last granted requester
MULT_START  out  1  to multipli START, one-cycle pulse
MULT_A  out  tamano  to multipli A, latched operand
MULT_B  out  tamano  to multipli B, latched operand
MULT_S  in  2*tamano  from multipli S
MULT_END  in  1  from multipli END_MULT

Behaviour:
- Reset (RESET=0, async): state=IDLE, ACK=0, ERR=0, RESULT=0, BUSY=0, GRANT_ID=0, MULT_START=0, MULT_A=0, MULT_B=0, RR pointer=0, watchdog=0. Takes effect immediately, including mid-operation; an in-flight op is dropped with no ACK.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any REQ=1 and MULT_END=0, grant the first set REQ starting at index ptr and searching upward with wrap. Latch GRANT_ID, MULT_A/MULT_B from that requester's slices, set MULT_START=1, go ISSUE. Otherwise stay.
- ISSUE (1 cycle): MULT_START is high for exactly this cycle. Next state is WAIT with MULT_START=0. Watchdog cleared.
- WAIT: MULT_A/MULT_B held stable.
  - MULT_END sampled 1: RESULT<=MULT_S, ACK[GRANT_ID]<=1, ERR<=0, go DONE.
  - Watchdog reaches TIMEOUT-1 with MULT_END=0: RESULT<=0, ACK[GRANT_ID]<=1, ERR<=1, go DONE.
  - Otherwise: watchdog +1.
- DONE (1 cycle): ACK/ERR high this cycle only. ptr<=GRANT_ID+1 mod NREQ. MULT_END is ignored. Next state IDLE with ACK=0, ERR=0.
- Back-to-back: a new grant is possible at the first IDLE edge after DONE, provided MULT_END=0. Minimum spacing between START pulses is 4 cycles plus the multiplier latency.
- Request rules:
  - REQ dropped before grant: withdrawn, never served.
  - REQ dropped after grant: operation completes and ACK still pulses.
  - REQ_A/REQ_B changes after the IDLE grant edge: no effect on the current operation.
- Fairness: a requester holding REQ is served within NREQ grants.
- Arithmetic: no computation in this block; RESULT is MULT_S unmodified (unsigned, 2*tamano bits).
- Simultaneous MULT_END and timeout in the same WAIT cycle: MULT_END wins (ERR=0).

Test Plan:
- Reset: hold RESET=0 for 5 cycles mid-WAIT -> all outputs 0; MULT_START never pulses after release until a REQ is present.
- Single request: REQ=4'b0010, slice1 A=3, B=5 -> one MULT_START pulse, MULT_A=3, MULT_B=5; after MULT_END, ACK=4'b0010 for 1 cycle with RESULT=15, ERR=0, GRANT_ID=1.
- Round-robin: REQ=4'b1111 held continuously, operands i*10+1 and 2 -> ACK order 0,1,2,3,0. RESULTs are 2, 22, 42, 62, 2.
- Wrap and skip: ptr=3, REQ=4'b0101 -> grant 0 then 2; requester 3 is not granted.
- Timeout: tie MULT_END=0, REQ=4'b0001 -> ACK[0]=1 with ERR=1, RESULT=0 exactly TIMEOUT cycles after entering WAIT; the next request is served normally.
- Boundary values: A=255, B=255, then 200×150, then 0×0 from requester 2 -> RESULT=65025, then 30000, then 0. Dropping REQ[2] after grant still yields ACK[2].
